// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit.
//   cond_code_e : 4-bit condition code selecting which flag predicate counts
//                 as "taken".
//   flags_t     : packed flag word {Z,N,C,V}, Z in bit 3 down to V in bit 0.
//   FLAG_*      : bit positions of each flag inside a flags_t / 4-bit vector.
package cond_pkg;

    typedef enum logic [3:0] {
        CC_NEVER  = 4'd0,
        CC_EQ     = 4'd1,
        CC_LT     = 4'd2,
        CC_LE     = 4'd3,
        CC_ALWAYS = 4'd4,
        CC_NE     = 4'd5,
        CC_GE     = 4'd6,
        CC_GT     = 4'd7,
        CC_LTU    = 4'd8,
        CC_LEU    = 4'd9,
        CC_GEU    = 4'd10,
        CC_GTU    = 4'd11,
        CC_NEG    = 4'd12,
        CC_NNEG   = 4'd13,
        CC_OVF    = 4'd14,
        CC_NOVF   = 4'd15
    } cond_code_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator.
//   flags     : flag word {Z,N,C,V} to test
//   condition : 4-bit condition code (cond_code_e)
//   taken     : 1 when the selected predicate holds on flags
module cond_eval
    import cond_pkg::*;
(
    input  flags_t     flags,
    input  logic [3:0] condition,
    output logic       taken
);

    logic lt_s;

    // Signed less-than: negative result unless the subtraction overflowed.
    assign lt_s = flags.n ^ flags.v;

    always_comb begin
        taken = 1'b0;
        unique case (cond_code_e'(condition))
            CC_NEVER:  taken = 1'b0;
            CC_EQ:     taken = flags.z;
            CC_LT:     taken = lt_s;
            CC_LE:     taken = flags.z | lt_s;
            CC_ALWAYS: taken = 1'b1;
            CC_NE:     taken = !flags.z;
            CC_GE:     taken = !lt_s;
            CC_GT:     taken = !flags.z & !lt_s;
            CC_LTU:    taken = flags.c;
            CC_LEU:    taken = flags.c | flags.z;
            CC_GEU:    taken = !flags.c;
            CC_GTU:    taken = !flags.c & !flags.z;
            CC_NEG:    taken = flags.n;
            CC_NNEG:   taken = !flags.n;
            CC_OVF:    taken = flags.v;
            CC_NOVF:   taken = !flags.v;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: compares a against b (a - b), evaluates a condition code on
// either the fresh comparison flags or the stored flag register, and returns
// the result through a one-entry valid/ready output register. Also keeps a
// saturating count of taken results.
//   clk, rst        : clock, synchronous active-low reset
//   in_valid/ready  : request handshake (in_ready = !out_valid | out_ready)
//   out_ready       : downstream consumes the registered result
//   condition, a, b : condition code and operands (b = 0 tests a alone)
//   use_flags       : evaluate on the stored flags instead of a - b
//   flag_we         : on accept, load the flag register from a - b
//   cnt_clr         : clear taken_cnt (wins over an increment)
//   out_valid/taken : registered result, valid one cycle after accept
//   flags           : live flag register {Z,N,C,V}
//   taken_cnt       : saturating count of taken accepts
module cond_unit
    import cond_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    input  logic [3:0]       condition,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_flags,
    input  logic             flag_we,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             taken,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] taken_cnt
);

    // Flags of x - y. The extra top bit of the widened difference is the
    // unsigned borrow; overflow is an operand sign mismatch that the result
    // does not preserve.
    function automatic flags_t sub_flags(input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        flags_t         f;
        d   = {1'b0, x} - {1'b0, y};
        f.z = (d[WIDTH-1:0] == '0);
        f.n = d[WIDTH-1];
        f.c = d[WIDTH];
        f.v = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
        return f;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    flags_t flag_reg;
    flags_t cmp_flags;
    logic   taken_cmp;
    logic   taken_stored;
    logic   taken_next;
    logic   accept;

    assign cmp_flags = sub_flags(a, b);

    cond_eval u_eval_cmp (
        .flags     (cmp_flags),
        .condition (condition),
        .taken     (taken_cmp)
    );

    cond_eval u_eval_stored (
        .flags     (flag_reg),
        .condition (condition),
        .taken     (taken_stored)
    );

    assign taken_next = use_flags ? taken_stored : taken_cmp;

    // Held low during reset so no handshake can complete in that cycle.
    assign in_ready = rst & (!out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    assign flags = flag_reg;

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            taken     <= 1'b0;
            flag_reg  <= '0;
            taken_cnt <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                taken     <= taken_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Loads regardless of use_flags; evaluation above already used
            // the pre-edge value of flag_reg.
            if (accept && flag_we) begin
                flag_reg <= cmp_flags;
            end

            if (cnt_clr) begin
                taken_cnt <= '0;
            end else if (accept && taken_next) begin
                taken_cnt <= sat_inc(taken_cnt);
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic [3:0]    condition;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          use_flags;
    logic          flag_we;
    logic          cnt_clr;
    logic          out_valid;
    logic          taken;
    logic [3:0]    flags;
    logic [CW-1:0] taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cond_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .condition (condition),
        .a         (a),
        .b         (b),
        .use_flags (use_flags),
        .flag_we   (flag_we),
        .cnt_clr   (cnt_clr),
        .out_valid (out_valid),
        .taken     (taken),
        .flags     (flags),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic int sval(input logic [W-1:0] x);
        int u;
        u = x;
        return (u >= 128) ? u - 256 : u;
    endfunction

    // Flags {Z,N,C,V} of x - y from integer arithmetic.
    function automatic logic [3:0] m_flags_ab(input logic [W-1:0] x, input logic [W-1:0] y);
        int ux, uy, diff, wrapped;
        logic z, n, c, v;
        ux = x;
        uy = y;
        wrapped = (ux - uy + 256) % 256;
        diff = sval(x) - sval(y);
        z = (wrapped == 0);
        n = (wrapped >= 128);
        c = (ux < uy);
        v = (diff < -128) || (diff > 127);
        return {z, n, c, v};
    endfunction

    // Condition outcome from direct signed/unsigned comparison of operands.
    function automatic logic m_taken_ab(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [3:0] code);
        int ux, uy, sx, sy;
        logic [3:0] f;
        ux = x; uy = y; sx = sval(x); sy = sval(y);
        f = m_flags_ab(x, y);
        case (code)
            4'd0:  return 1'b0;
            4'd1:  return ux == uy;
            4'd2:  return sx < sy;
            4'd3:  return sx <= sy;
            4'd4:  return 1'b1;
            4'd5:  return ux != uy;
            4'd6:  return sx >= sy;
            4'd7:  return sx > sy;
            4'd8:  return ux < uy;
            4'd9:  return ux <= uy;
            4'd10: return ux >= uy;
            4'd11: return ux > uy;
            4'd12: return f[2];
            4'd13: return !f[2];
            4'd14: return f[0];
            default: return !f[0];
        endcase
    endfunction

    // Condition outcome from a stored flag word.
    function automatic logic m_taken_f(input logic [3:0] f, input logic [3:0] code);
        logic z, n, c, v;
        {z, n, c, v} = f;
        case (code)
            4'd0:  return 1'b0;
            4'd1:  return z;
            4'd2:  return n != v;
            4'd3:  return z || (n != v);
            4'd4:  return 1'b1;
            4'd5:  return !z;
            4'd6:  return n == v;
            4'd7:  return !z && (n == v);
            4'd8:  return c;
            4'd9:  return c || z;
            4'd10: return !c;
            4'd11: return !c && !z;
            4'd12: return n;
            4'd13: return !n;
            4'd14: return v;
            default: return !v;
        endcase
    endfunction

    logic       m_live = 1'b0;
    logic       m_valid;
    logic       m_taken;
    logic [3:0] m_flags;
    int         m_cnt;

    always @(posedge clk) begin
        logic rdy, acc, tk;
        if (!rst) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_taken = 1'b0;
            m_flags = 4'b0000;
            m_cnt   = 0;
        end else if (m_live) begin
            rdy = !m_valid || out_ready;
            acc = in_valid && rdy;
            tk  = use_flags ? m_taken_f(m_flags, condition) : m_taken_ab(a, b, condition);
            if (acc) begin
                m_valid = 1'b1;
                m_taken = tk;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (acc && flag_we) m_flags = m_flags_ab(a, b);
            if (cnt_clr) m_cnt = 0;
            else if (acc && tk && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    end

    // Inputs change 2 time units after the rising edge, so the falling edge
    // sees stable inputs and settled registered outputs.
    always @(negedge clk) begin
        if (m_live) begin
            check("model_in_ready", in_ready, rst && (!m_valid || out_ready));
            check("model_out_valid", out_valid, m_valid);
            if (m_valid) check("model_taken", taken, m_taken);
            check("model_flags", flags, m_flags);
            check("model_taken_cnt", taken_cnt, m_cnt);
        end
    end

    // ---------------- directed helpers ----------------
    // Entered and left at posedge+2. Issues one accept and returns the taken
    // value seen one cycle later.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] tc,
                        input logic tuf, input logic tfw, input logic tclr, output logic tk);
        in_valid = 1'b1; a = ta; b = tb; condition = tc;
        use_flags = tuf; flag_we = tfw; cnt_clr = tclr; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; use_flags = 1'b0; flag_we = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        check("valid_after_accept", out_valid, 1'b1);
        tk = taken;
        @(posedge clk); #2;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'h7F;
            3: return 8'hFF;
            4: return 8'h01;
            default: return W'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic tk;
        logic held;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; condition = 4'd0;
        a = '0; b = '0; use_flags = 1'b0; flag_we = 1'b0; cnt_clr = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #2;
        check("rst_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_taken", taken, 1'b0);
        check("rst_flags", flags, 4'b0000);
        check("rst_cnt", taken_cnt, 16'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #2;

        // Single-operand tests (b = 0)
        send(8'h00, 8'h00, 4'd1, 0, 0, 0, tk); check("b0_eq_zero", tk, 1'b1);
        send(8'h80, 8'h00, 4'd2, 0, 0, 0, tk); check("b0_lt_neg", tk, 1'b1);
        send(8'h01, 8'h00, 4'd7, 0, 0, 0, tk); check("b0_gt_pos", tk, 1'b1);
        send(8'h01, 8'h00, 4'd0, 0, 0, 0, tk); check("b0_never", tk, 1'b0);

        // Signed vs unsigned ordering
        send(8'h01, 8'hFF, 4'd2,  0, 0, 0, tk); check("lt_1_m1", tk, 1'b0);
        send(8'h01, 8'hFF, 4'd8,  0, 0, 0, tk); check("ltu_1_ff", tk, 1'b1);
        send(8'h01, 8'hFF, 4'd11, 0, 0, 0, tk); check("gtu_1_ff", tk, 1'b0);

        // Overflow case
        send(8'h80, 8'h01, 4'd2, 0, 1, 0, tk); check("ovf_lt", tk, 1'b1);
        check("ovf_flags", flags, 4'b0001);
        send(8'h80, 8'h01, 4'd14, 0, 0, 0, tk); check("ovf_code14", tk, 1'b1);

        // Stored flags
        send(8'd5, 8'd5, 4'd0, 0, 1, 0, tk);
        check("store_eq_flags", flags, 4'b1000);
        send(8'd3, 8'd7, 4'd1, 1, 0, 0, tk); check("use_flags_eq", tk, 1'b1);
        send(8'd3, 8'd7, 4'd1, 1, 1, 0, tk); check("use_and_write_old", tk, 1'b1);
        check("use_and_write_new", flags, 4'b0110);
        send(8'd0, 8'd0, 4'd1, 1, 0, 0, tk); check("use_flags_after", tk, 1'b0);

        // Backpressure
        in_valid = 1'b1; a = 8'h00; b = 8'h00; condition = 4'd1; out_ready = 1'b1;
        @(posedge clk); #2;
        a = 8'h01; out_ready = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_valid", out_valid, 1'b1);
            check("stall_taken", taken, held);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        check("release_new_valid", out_valid, 1'b1);
        check("release_new_taken", taken, 1'b0);
        @(posedge clk); #2;

        // Reset mid-transaction
        in_valid = 1'b1; a = 8'd3; b = 8'd7; condition = 4'd4; flag_we = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        flag_we = 1'b0; out_ready = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_flags", flags, 4'b0000);
        check("midrst_cnt", taken_cnt, 16'd0);
        check("midrst_ready", in_ready, 1'b1);
        @(posedge clk); #2;

        // Randomized traffic
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            a         = pick();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = 8'h00;
                default: b = pick();
            endcase
            condition = 4'($urandom_range(0, 15));
            use_flags = ($urandom_range(0, 9) < 3);
            flag_we   = ($urandom_range(0, 9) < 4);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 99) != 0);
            @(posedge clk); #2;
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        use_flags = 1'b0; flag_we = 1'b0; cnt_clr = 1'b0;
        @(posedge clk); #2;

        // Counter saturation
        cnt_clr = 1'b1;
        @(posedge clk); #2;
        cnt_clr = 1'b0;
        in_valid = 1'b1; condition = 4'd4;
        repeat (65535) @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(negedge clk);
        check("cnt_full", taken_cnt, 16'hFFFF);
        @(posedge clk); #2;
        send(8'h00, 8'h00, 4'd4, 0, 0, 0, tk);
        check("cnt_saturated", taken_cnt, 16'hFFFF);
        send(8'h00, 8'h00, 4'd4, 0, 0, 1, tk);
        check("cnt_clr_wins", taken_cnt, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
